// File: rtl/vga_frame_scanner_if.sv
// SRAM read port between the frame scanner and the arbiter.
// The master issues word addresses with a read strobe, and the slave returns RGB565 data.
interface vga_frame_scanner_if #(
  parameter int unsigned ADDR_W = 20
) ();
  logic [ADDR_W-1:0] sram_address;
  logic              sram_rd;
  logic [15:0]       sram_data;

  modport master (
    output sram_address,
    output sram_rd,
    input  sram_data
  );

  modport slave (
    input  sram_address,
    input  sram_rd,
    output sram_data
  );
endinterface

// File: rtl/vga_frame_scanner.sv
// Programmable VGA timing generator with SRAM pixel fetch, integer upscaling and
// double-buffer selection. It runs one frame per request or frames back to back.
module vga_frame_scanner #(
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter bit          SYNC_POL  = 1'b0,
  parameter int unsigned SCALE     = 1,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned BUF0_BASE = 0,
  parameter int unsigned BUF1_BASE = 'h4B000
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_en,
  input  logic                       i_cont,
  input  logic                       i_buf_sel,
  vga_frame_scanner_if.master        sram_io,
  output logic                       o_hs,
  output logic                       o_vs,
  output logic                       o_de,
  output logic [4:0]                 o_red,
  output logic [5:0]                 o_green,
  output logic [4:0]                 o_blue,
  output logic                       o_frame_start,
  output logic                       o_frame_finish
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);
  localparam int unsigned SW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int unsigned DW = $clog2(READ_LAT + 2);

  localparam logic [HW-1:0] HLast     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HSyncEnd  = HW'(H_SYNC);
  localparam logic [HW-1:0] HActFirst = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] HActLast  = HW'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [VW-1:0] VLast     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VSyncEnd  = VW'(V_SYNC);
  localparam logic [VW-1:0] VActFirst = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] VActLast  = VW'(V_SYNC + V_BACK + V_ACTIVE - 1);
  localparam logic [SW-1:0] SubLast   = SW'(SCALE - 1);
  localparam logic [DW-1:0] DrainLast = DW'(READ_LAT + 1);
  localparam logic [ADDR_W-1:0] SrcW  = ADDR_W'(H_ACTIVE / SCALE);
  localparam logic [ADDR_W-1:0] Buf0  = ADDR_W'(BUF0_BASE);
  localparam logic [ADDR_W-1:0] Buf1  = ADDR_W'(BUF1_BASE);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e            state_q, state_d;
  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic              cont_q;
  logic [ADDR_W-1:0] base_q;
  logic [SW-1:0]     x_sub_q, x_sub_d, y_sub_q, y_sub_d;
  logic [ADDR_W-1:0] col_q, col_d, line_base_q, line_base_d;

  logic run, last_cyc, frame_begin, pix_act, last_pix;
  logic [ADDR_W-1:0] addr_calc;

  // Sideband per pixel slot: {last pixel, de, vsync active, hsync active}
  logic [3:0]                 sb_in, sb_out;
  logic [READ_LAT+1:0][3:0]   sb_q;
  logic [ADDR_W-1:0]          addr_q;
  logic                       rd_q;
  logic [15:0]                data_q, rgb_q;
  logic                       hs_q, vs_q, de_q, last_q, fin_q;

  assign last_cyc  = (h_q == HLast) && (v_q == VLast);
  assign pix_act   = run && (h_q >= HActFirst) && (h_q <= HActLast)
                         && (v_q >= VActFirst) && (v_q <= VActLast);
  assign last_pix  = pix_act && (h_q == HActLast) && (v_q == VActLast);
  assign addr_calc = base_q + line_base_q + col_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_begin = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_en) begin
          state_d     = StRun;
          frame_begin = 1'b1;
        end
      end
      StRun: begin
        if (last_cyc) begin
          if (cont_q && i_en) frame_begin = 1'b1;
          else                state_d     = StDrain;
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    run = 1'b0;
    unique case (state_q)
      StRun:   run = 1'b1;
      default: run = 1'b0;
    endcase
  end

  assign o_frame_start = run && (h_q == '0) && (v_q == '0);

  always_comb begin
    h_d     = '0;
    v_d     = '0;
    drain_d = '0;
    if (run) begin
      if (h_q == HLast) begin
        v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
        v_d = v_q;
      end
    end
    if (state_q == StDrain) drain_d = drain_q + 1'b1;
  end

  // Upscaling walks source columns/lines by sub-counters instead of dividing h and v.
  always_comb begin
    x_sub_d     = x_sub_q;
    y_sub_d     = y_sub_q;
    col_d       = col_q;
    line_base_d = line_base_q;
    if (!run || last_cyc) begin
      x_sub_d     = '0;
      y_sub_d     = '0;
      col_d       = '0;
      line_base_d = '0;
    end else if (pix_act) begin
      if (h_q == HActLast) begin
        x_sub_d = '0;
        col_d   = '0;
        if (y_sub_q == SubLast) begin
          y_sub_d     = '0;
          line_base_d = line_base_q + SrcW;
        end else begin
          y_sub_d = y_sub_q + 1'b1;
        end
      end else if (x_sub_q == SubLast) begin
        x_sub_d = '0;
        col_d   = col_q + 1'b1;
      end else begin
        x_sub_d = x_sub_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_q         <= '0;
      v_q         <= '0;
      drain_q     <= '0;
      cont_q      <= 1'b0;
      base_q      <= '0;
      x_sub_q     <= '0;
      y_sub_q     <= '0;
      col_q       <= '0;
      line_base_q <= '0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      drain_q     <= drain_d;
      x_sub_q     <= x_sub_d;
      y_sub_q     <= y_sub_d;
      col_q       <= col_d;
      line_base_q <= line_base_d;
      if (frame_begin) begin
        cont_q <= i_cont;
        base_q <= i_buf_sel ? Buf1 : Buf0;
      end
    end
  end

  assign sb_in  = {last_pix, pix_act, run && (v_q < VSyncEnd), run && (h_q < HSyncEnd)};
  assign sb_out = sb_q[READ_LAT+1];

  // Sideband is delayed to line up with data_q, then everything is registered onto the pins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_q   <= 1'b0;
      addr_q <= '0;
      sb_q   <= '0;
      data_q <= '0;
      hs_q   <= ~SYNC_POL;
      vs_q   <= ~SYNC_POL;
      de_q   <= 1'b0;
      rgb_q  <= '0;
      last_q <= 1'b0;
      fin_q  <= 1'b0;
    end else begin
      rd_q <= pix_act;
      if (pix_act) addr_q <= addr_calc;
      sb_q   <= {sb_q[READ_LAT:0], sb_in};
      data_q <= sram_io.sram_data;
      hs_q   <= sb_out[0] ? SYNC_POL : ~SYNC_POL;
      vs_q   <= sb_out[1] ? SYNC_POL : ~SYNC_POL;
      de_q   <= sb_out[2];
      rgb_q  <= sb_out[2] ? data_q : 16'h0000;
      last_q <= sb_out[3];
      fin_q  <= last_q;
    end
  end

  assign sram_io.sram_address = addr_q;
  assign sram_io.sram_rd      = rd_q;
  assign o_hs           = hs_q;
  assign o_vs           = vs_q;
  assign o_de           = de_q;
  assign o_red          = rgb_q[15:11];
  assign o_green        = rgb_q[10:5];
  assign o_blue         = rgb_q[4:0];
  assign o_frame_finish = fin_q;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Scoreboard bench for vga_frame_scanner on a shrunken timing set with 2x upscale,
// a two-cycle SRAM read latency and a buffer base that wraps the address space.
module tb_vga_frame_scanner;
  localparam int unsigned HS = 3, HB = 2, HA = 8, HF = 2;
  localparam int unsigned VS = 1, VB = 1, VA = 4, VF = 1;
  localparam int unsigned SC = 2, RL = 2, AW = 12;
  localparam int unsigned BASE0 = 'h100, BASE1 = 'hFF8;
  localparam int FRAME = (HS + HB + HA + HF) * (VS + VB + VA + VF);

  logic clk, rst_n, en, cont, buf_sel;
  logic hs, vs, de, fs, ff;
  logic [4:0] red, blue;
  logic [5:0] green;
  logic [15:0] rgb;
  logic [AW-1:0] lat1, lat2;

  vga_frame_scanner_if #(.ADDR_W(AW)) sram ();

  vga_frame_scanner #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .SYNC_POL(1'b0), .SCALE(SC), .READ_LAT(RL), .ADDR_W(AW),
    .BUF0_BASE(BASE0), .BUF1_BASE(BASE1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_cont(cont), .i_buf_sel(buf_sel),
    .sram_io(sram),
    .o_hs(hs), .o_vs(vs), .o_de(de), .o_red(red), .o_green(green), .o_blue(blue),
    .o_frame_start(fs), .o_frame_finish(ff)
  );

  assign rgb = {red, green, blue};

  function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
    return {a[3:0], a} ^ 16'h5A3C;
  endfunction

  // SRAM model: data appears RL cycles after the address is presented.
  always @(posedge clk) begin
    lat1 <= sram.sram_address;
    lat2 <= lat1;
  end
  assign sram.sram_data = mem_word(lat2);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0, n_bad = 0;
  int cyc = 0, since = 0;
  int n_start = 0, n_fin = 0, n_de = 0, n_rd = 0, n_hs_low = 0, n_vs_low = 0;
  int prev_start = 0, last_start = 0, hs_lat = 0, rd_cyc = 0, de_cyc = 0;
  int last_de = 0, fin_gap = 0, de_in_frame = 0, de_at_fin = 0;
  bit need_hs = 0, need_rd = 0, need_de = 0;
  logic [AW-1:0] exp_a[$];
  logic [15:0]   exp_p[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int cnt(input int which);
    case (which)
      0:       return n_start;
      1:       return n_fin;
      default: return n_de;
    endcase
  endfunction

  task automatic wait_cnt(input string tag, input int which, input int target, input int budget);
    int k = 0;
    while (cnt(which) < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(cnt(which) >= target), 1);
  endtask

  task automatic mon();
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        exp_a.delete();
        exp_p.delete();
      end else begin
        if (fs) begin
          n_start++;
          prev_start  = last_start;
          last_start  = cyc;
          need_hs     = 1;
          need_rd     = 1;
          need_de     = 1;
          since       = 0;
          de_in_frame = 0;
          for (int y = 0; y < int'(VA); y++) begin
            for (int x = 0; x < int'(HA); x++) begin
              a = AW'((buf_sel ? BASE1 : BASE0) + (y / SC) * (HA / SC) + x / SC);
              exp_a.push_back(a);
              exp_p.push_back(mem_word(a));
            end
          end
        end else begin
          since++;
        end
        if (!hs) begin
          n_hs_low++;
          if (need_hs) begin
            hs_lat  = since;
            need_hs = 0;
          end
        end
        if (!vs) n_vs_low++;
        if (sram.sram_rd) begin
          n_rd++;
          if (need_rd) begin
            rd_cyc  = cyc;
            need_rd = 0;
          end
          if (exp_a.size() > 0) chk("sram_addr", 32'(sram.sram_address), 32'(exp_a.pop_front()));
          else                  chk("addr_q_empty", 32'(sram.sram_rd), 0);
        end
        if (de) begin
          n_de++;
          de_in_frame++;
          last_de = cyc;
          if (need_de) begin
            de_cyc  = cyc;
            need_de = 0;
          end
          if (exp_p.size() > 0) chk("pixel", 32'(rgb), 32'(exp_p.pop_front()));
          else                  chk("pix_q_empty", 32'(de), 0);
        end else begin
          chk("rgb_blank", 32'(rgb), 0);
        end
        if (ff) begin
          n_fin++;
          fin_gap   = cyc - last_de;
          de_at_fin = de_in_frame;
        end
      end
    end
  endtask

  int s_start, s_fin, s_de, s_hs, s_vs, s_rd;

  task automatic snap();
    s_start = n_start;
    s_fin   = n_fin;
    s_de    = n_de;
    s_hs    = n_hs_low;
    s_vs    = n_vs_low;
    s_rd    = n_rd;
  endtask

  task automatic chk_pins_reset(input string tag);
    chk({tag, "_hs"}, 32'(hs), 1);
    chk({tag, "_vs"}, 32'(vs), 1);
    chk({tag, "_de"}, 32'(de), 0);
    chk({tag, "_rgb"}, 32'(rgb), 0);
    chk({tag, "_rd"}, 32'(sram.sram_rd), 0);
    chk({tag, "_addr"}, 32'(sram.sram_address), 0);
    chk({tag, "_fstart"}, 32'(fs), 0);
    chk({tag, "_ffinish"}, 32'(ff), 0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; cont = 1'b0; buf_sel = 1'b0;
    fork
      mon();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk_pins_reset("reset");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Single frame from a one-cycle request.
    snap();
    #1 en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    wait_cnt("single_fin_wait", 1, s_fin + 1, 3 * FRAME);
    repeat (20) @(negedge clk);
    chk("single_starts", n_start - s_start, 1);
    chk("single_fins", n_fin - s_fin, 1);
    chk("single_hs_low", n_hs_low - s_hs, HS * (VS + VB + VA + VF));
    chk("single_vs_low", n_vs_low - s_vs, VS * (HS + HB + HA + HF));
    chk("single_de", n_de - s_de, HA * VA);
    chk("hs_latency", hs_lat, 3 + RL);
    chk("rd_to_de", de_cyc - rd_cyc, 2 + RL);
    chk("finish_after_last_de", fin_gap, 1);
    chk("de_at_finish", de_at_fin, HA * VA);
    chk("addr_q_left", exp_a.size(), 0);
    chk("pix_q_left", exp_p.size(), 0);

    // Single mode with request held: frames separated by drain plus one idle cycle.
    snap();
    @(posedge clk);
    #1 en = 1'b1;
    wait_cnt("restart_wait", 0, s_start + 2, 3 * FRAME);
    @(posedge clk);
    #1 en = 1'b0;
    wait_cnt("restart_fin_wait", 1, s_fin + 2, 3 * FRAME);
    repeat (20) @(negedge clk);
    chk("restart_gap", last_start - prev_start, FRAME + RL + 3);
    chk("restart_starts", n_start - s_start, 2);

    // Continuous: buffer select changes mid-frame only take effect at the next frame.
    snap();
    @(posedge clk);
    #1 begin cont = 1'b1; buf_sel = 1'b0; en = 1'b1; end
    wait_cnt("cont_f0_wait", 0, s_start + 1, 2 * FRAME);
    repeat (50) @(posedge clk);
    #1 buf_sel = 1'b1;
    wait_cnt("cont_f1_wait", 0, s_start + 2, 2 * FRAME);
    repeat (52) @(posedge clk);
    #1 begin en = 1'b0; buf_sel = 1'b0; end
    wait_cnt("cont_fin_wait", 1, s_fin + 2, 2 * FRAME);
    repeat (30) @(negedge clk);
    chk("cont_gap", last_start - prev_start, FRAME);
    chk("cont_starts", n_start - s_start, 2);
    chk("cont_fins", n_fin - s_fin, 2);
    chk("cont_de", n_de - s_de, 2 * HA * VA);
    chk("cont_addr_q_left", exp_a.size(), 0);

    // Reset in the middle of the active area.
    snap();
    @(posedge clk);
    #1 begin cont = 1'b0; en = 1'b1; end
    @(posedge clk);
    #1 en = 1'b0;
    wait_cnt("mid_de_wait", 2, s_de + 10, 2 * FRAME);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_pins_reset("midreset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    s_rd = n_rd;
    s_start = n_start;
    repeat (40) @(negedge clk);
    chk("idle_no_rd", n_rd - s_rd, 0);
    chk("idle_no_start", n_start - s_start, 0);
    chk("reset_no_finish", n_fin - s_fin, 0);
    chk("idle_de", 32'(de), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
